sign_narrow16: RTL

SIGN_NARROW16 -- requirements
Module: sign_narrow16

---
 rtl/sign_narrow16.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sign_narrow16.sv
// Narrows a signed 16-bit word to 8 bits behind a 2-entry ready/valid FIFO, flagging and counting out-of-range inputs.
// Optional build macro SIGN_NARROW16_SATURATE_EN: clamp out-of-range results to 8'h7F / 8'h80 instead of truncating.
module sign_narrow16 #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       r,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Exactly recoverable by 8-to-16 sign extension when the top nine bits agree.
  function automatic logic in_range(input logic [15:0] v);
    return (v[15:7] == 9'h000) || (v[15:7] == 9'h1FF);
  endfunction

  function automatic logic [7:0] narrow(input logic [15:0] v);
`ifdef SIGN_NARROW16_SATURATE_EN
    if (in_range(v)) begin
      return v[7:0];
    end else if (v[15]) begin
      return 8'h80;
    end else begin
      return 8'h7F;
    end
`else
    return v[7:0];
`endif
  endfunction

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [7:0]       head_data_r;
  logic             head_ovf_r;
  logic [7:0]       tail_data_r;
  logic             tail_ovf_r;
  logic [CNT_W-1:0] count_r;

  logic       push_s;
  logic       pop_s;
  logic [7:0] new_data_s;
  logic       new_ovf_s;

  // Handshake decode and the narrowed value of the word on the input.
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    new_data_s = 8'h00;
    new_ovf_s  = 1'b0;
    if (in_valid && in_ready_r) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (out_valid_r && out_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    new_data_s = narrow(in);
    new_ovf_s  = ~in_range(in);
  end

  // FIFO state machine; head holds the word on r/ovf, tail holds the second entry when FULL.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_data_r <= 8'h00;
      head_ovf_r  <= 1'b0;
      tail_data_r <= 8'h00;
      tail_ovf_r  <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_data_r <= new_data_s;
            head_ovf_r  <= new_ovf_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_data_r <= new_data_s;
            head_ovf_r  <= new_ovf_s;
          end else if (push_s) begin
            tail_data_r <= new_data_s;
            tail_ovf_r  <= new_ovf_s;
            state_r     <= FULL;
            in_ready_r  <= 1'b0;
          end else if (pop_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_data_r <= tail_data_r;
            head_ovf_r  <= tail_ovf_r;
            state_r     <= ONE;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted out-of-range words.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (push_s && new_ovf_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r         = head_data_r;
  assign ovf       = head_ovf_r;
  assign ovf_count = count_r;

endmodule
